ysyx_25040129_axil_sram: RTL

AXI4-Lite-style memory responder (slave) that terminates the load/store channels driven by the core's LSU. It implements independent read and write channel FSMs over a word-organised on-chip array, with configurable or pseudo-random response latency. It is used both as a simulation data memory and as a stress target for the LSU handshake logic.

---
 rtl/ysyx_25040129_axil_sram_pkg.sv | 37 +++
 rtl/ysyx_25040129_axil_sram_if.sv | 35 +++
 rtl/ysyx_25040129_lfsr8.sv | 23 ++
 rtl/ysyx_25040129_axil_sram.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040129_axil_sram_pkg.sv
// Shared encodings for the AXI4-Lite SRAM responder: response codes, transfer
// sizes, channel FSM states and the wstrb legality check.
package ysyx_25040129_axil_sram_pkg;

  localparam logic [1:0] ysyx_25040129_OKAY   = 2'b00;
  localparam logic [1:0] ysyx_25040129_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } size_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } r_state_e;

  typedef enum logic [2:0] {
    W_IDLE,
    W_GOT_AW,
    W_GOT_W,
    W_WAIT,
    W_RESP
  } w_state_e;

  // Legal strobes: none, one byte, an aligned half, or the full word.
  function automatic logic strb_ok(input logic [3:0] s);
    case (s)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25040129_axil_sram_if.sv
// AXI4-Lite load/store channels between the LSU (master) and the SRAM (slave).
interface ysyx_25040129_axil_sram_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [2:0]  arsize;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, arsize, rready,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, arsize, rready,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_25040129_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, used for random latency.
module ysyx_25040129_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/ysyx_25040129_axil_sram.sv
// AXI4-Lite SRAM responder: independent read and write FSMs over a word array,
// with fixed or LFSR-driven response latency.
module ysyx_25040129_axil_sram
  import ysyx_25040129_axil_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0f00_0000,
  parameter int          DEPTH_WORDS = 2048,
  parameter int          RD_DELAY    = 1,
  parameter int          WR_DELAY    = 1,
  parameter int          RAND_DELAY  = 0,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_25040129_axil_sram_if.slave  bus
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  logic [7:0] lfsr;
  logic       lfsr_unused;
  logic [3:0] rd_delay, wr_delay;

  ysyx_25040129_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign lfsr_unused = ^lfsr[7:3];
  assign rd_delay    = (RAND_DELAY != 0) ? {1'b0, lfsr[2:0]} : 4'(RD_DELAY);
  assign wr_delay    = (RAND_DELAY != 0) ? {1'b0, lfsr[2:0]} : 4'(WR_DELAY);

  // ---------------------------------------------------------------- read
  r_state_e    r_state_q, r_state_d;
  logic [31:0] raddr_q, raddr_d;
  logic [2:0]  rsize_q, rsize_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rd_sample, rd_err;
  logic [31:0] rd_addr;
  logic [2:0]  rd_size;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rsize_d   = rsize_q;
    rcnt_d    = rcnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_sample = 1'b0;
    rd_addr   = raddr_q;
    rd_size   = rsize_q;
    case (r_state_q)
      R_IDLE: if (bus.arvalid) begin
        raddr_d = bus.araddr;
        rsize_d = bus.arsize;
        rcnt_d  = rd_delay;
        rd_addr = bus.araddr;
        rd_size = bus.arsize;
        if (rd_delay == 4'd0) begin
          r_state_d = R_RESP;
          rd_sample = 1'b1;
        end else begin
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        rcnt_d = rcnt_q - 4'd1;
        if (rcnt_q == 4'd1) begin
          r_state_d = R_RESP;
          rd_sample = 1'b1;
        end
      end
      R_RESP:  if (bus.rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
    rd_err = !in_range(rd_addr)
           || (rd_size == SIZE_HALF && rd_addr[0])
           || (rd_size == SIZE_WORD && rd_addr[1:0] != 2'b00);
    // Sampling the array before the write commit lands gives old data on a same-edge hit.
    if (rd_sample) begin
      rresp_d = rd_err ? ysyx_25040129_SLVERR : ysyx_25040129_OKAY;
      rdata_d = rd_err ? 32'h0 : mem[word_idx(rd_addr)];
    end
  end

  // NOTE: sequential state is assigned only with non-blocking <= so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rsize_q   <= '0;
      rcnt_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= ysyx_25040129_OKAY;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rsize_q   <= rsize_d;
      rcnt_q    <= rcnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign bus.arready = !rst && (r_state_q == R_IDLE);
  assign bus.rvalid  = !rst && (r_state_q == R_RESP);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

  // --------------------------------------------------------------- write
  w_state_e    w_state_q, w_state_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        aw_rdy, w_rdy, aw_hs, w_hs;
  logic        wr_done, wr_commit, wr_err, mem_we;
  logic [31:0] eff_addr, eff_data;
  logic [3:0]  eff_strb;
  logic [IDX_W-1:0] wr_idx;

  assign aw_rdy = !rst && (w_state_q == W_IDLE || w_state_q == W_GOT_W);
  assign w_rdy  = !rst && (w_state_q == W_IDLE || w_state_q == W_GOT_AW);
  assign aw_hs  = bus.awvalid && aw_rdy;
  assign w_hs   = bus.wvalid && w_rdy;

  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = aw_hs ? bus.awaddr : waddr_q;
    wdata_d   = w_hs  ? bus.wdata  : wdata_q;
    wstrb_d   = w_hs  ? bus.wstrb  : wstrb_q;
    wcnt_d    = wcnt_q;
    bresp_d   = bresp_q;
    wr_done   = 1'b0;
    wr_commit = 1'b0;
    // With a zero delay the commit happens on the completing handshake edge,
    // so the live channel values bypass the capture registers.
    eff_addr  = waddr_d;
    eff_data  = wdata_d;
    eff_strb  = wstrb_d;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) wr_done   = 1'b1;
        else if (aw_hs)    w_state_d = W_GOT_AW;
        else if (w_hs)     w_state_d = W_GOT_W;
      end
      W_GOT_AW: if (w_hs)  wr_done = 1'b1;
      W_GOT_W:  if (aw_hs) wr_done = 1'b1;
      W_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) begin
          w_state_d = W_RESP;
          wr_commit = 1'b1;
        end
      end
      W_RESP:  if (bus.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    if (wr_done) begin
      wcnt_d = wr_delay;
      if (wr_delay == 4'd0) begin
        w_state_d = W_RESP;
        wr_commit = 1'b1;
      end else begin
        w_state_d = W_WAIT;
      end
    end
    wr_err = !in_range(eff_addr) || !strb_ok(eff_strb);
    if (wr_commit) bresp_d = wr_err ? ysyx_25040129_SLVERR : ysyx_25040129_OKAY;
    mem_we = wr_commit && !wr_err && !rst;
    wr_idx = word_idx(eff_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wcnt_q    <= '0;
      bresp_q   <= ysyx_25040129_OKAY;
    end else begin
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wcnt_q    <= wcnt_d;
      bresp_q   <= bresp_d;
    end
  end

  // NOTE: the array has no reset; clearing it would forbid RAM inference and
  // reset must leave memory contents intact anyway.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (eff_strb[b]) mem[wr_idx][8*b +: 8] <= eff_data[8*b +: 8];
      end
    end
  end

  assign bus.awready = aw_rdy;
  assign bus.wready  = w_rdy;
  assign bus.bvalid  = !rst && (w_state_q == W_RESP);
  assign bus.bresp   = bresp_q;

endmodule
